// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - M pipeline stage with req/ack data memory handshake, stall and watchdog
module mem_access_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic             RegWE,
  input  logic             MemWE,
  input  logic             MemtoRegE,
  input  logic [3:0]       WA3E,
  input  logic             ValidE,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             StallM,
  output logic             ValidW,
  output logic             RegWW,
  output logic             MemtoRegW,
  output logic [WIDTH-1:0] ALUOutW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [3:0]       WA3W,
  output logic             MemErr
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] ALUResultM, WriteDataM;
  logic             RegWM, MemWM, MemtoRegM, ValidM;
  logic [3:0]       WA3M;
  logic [CW-1:0]    cnt;

  logic memopM;
  logic ack_hit;
  logic timeout_hit;
  logic start_access;
  logic w_load;
  logic w_timeout;
  logic rd_load;

  assign memopM      = ValidM & (MemWM | MemtoRegM);
  // ack takes priority, so timeout alone only counts when ack is absent
  assign ack_hit     = (state == ACCESS) & mem_ack;
  assign timeout_hit = (state == ACCESS) & (cnt == CNT_MAX);
  assign StallM      = memopM & ~(ack_hit | timeout_hit);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and W-stage load decisions
  always_comb begin
    state_next   = state;
    start_access = 1'b0;
    w_load       = 1'b0;
    w_timeout    = 1'b0;
    rd_load      = 1'b0;
    case (state)
      IDLE: begin
        if (memopM) begin
          state_next   = ACCESS;
          start_access = 1'b1;
        end else if (ValidM) begin
          w_load = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_next = IDLE;
          w_load     = 1'b1;
          rd_load    = MemtoRegM;
        end else if (timeout_hit) begin
          state_next = IDLE;
          w_timeout  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // M register: captures execute outputs unless the stage is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      RegWM      <= 1'b0;
      MemWM      <= 1'b0;
      MemtoRegM  <= 1'b0;
      WA3M       <= '0;
      ValidM     <= 1'b0;
    end else if (!StallM) begin
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      RegWM      <= RegWE;
      MemWM      <= MemWE;
      MemtoRegM  <= MemtoRegE;
      WA3M       <= WA3E;
      ValidM     <= ValidE;
    end
  end

  // Memory interface registers and watchdog counter; held stable for the whole access
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
    end else if (start_access) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWM;
      mem_addr  <= ALUResultM;
      mem_wdata <= WriteDataM;
      cnt       <= '0;
    end else if (state == ACCESS) begin
      if (mem_ack || timeout_hit) mem_req <= 1'b0;
      else                        cnt     <= cnt + 1'b1;
    end
  end

  // W register: completed instruction, or a bubble that keeps the old data
  always_ff @(posedge clk) begin
    if (rst) begin
      ValidW    <= 1'b0;
      RegWW     <= 1'b0;
      MemtoRegW <= 1'b0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
      WA3W      <= '0;
    end else if (w_load || w_timeout) begin
      ValidW    <= 1'b1;
      RegWW     <= w_timeout ? 1'b0 : RegWM;
      MemtoRegW <= MemtoRegM;
      ALUOutW   <= ALUResultM;
      WA3W      <= WA3M;
      if (w_timeout)    ReadDataW <= '0;
      else if (rd_load) ReadDataW <= mem_rdata;
    end else begin
      ValidW <= 1'b0;
      RegWW  <= 1'b0;
    end
  end

  // Sticky watchdog error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                         MemErr <= 1'b0;
    else if (timeout_hit && !mem_ack) MemErr <= 1'b1;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultE, WriteDataE;
  logic        RegWE, MemWE, MemtoRegE, ValidE;
  logic [3:0]  WA3E;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        StallM, ValidW, RegWW, MemtoRegW, MemErr;
  logic [31:0] ALUOutW, ReadDataW;
  logic [3:0]  WA3W;

  int vectors = 0;
  int miscompares = 0;
  int req_cycles;
  int stall_cycles;

  mem_access_stage #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .RegWE(RegWE), .MemWE(MemWE), .MemtoRegE(MemtoRegE),
    .WA3E(WA3E), .ValidE(ValidE),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .StallM(StallM), .ValidW(ValidW), .RegWW(RegWW), .MemtoRegW(MemtoRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WA3W(WA3W), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_e(input logic v, input logic rw, input logic mw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
    ValidE = v; RegWE = rw; MemWE = mw; MemtoRegE = m2r;
    ALUResultE = alu; WriteDataE = wd; WA3E = wa;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive_e(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_validw", {31'd0, ValidW}, 32'd0);
    chk("rst_memerr", {31'd0, MemErr}, 32'd0);
    chk("rst_aluoutw", ALUOutW, 32'd0);

    // ALU op: one-cycle M->W
    drive_e(1, 1, 0, 0, 32'h0000_00A5, 32'h0, 4'd3);
    step();
    chk("alu_stall", {31'd0, StallM}, 32'd0);
    chk("alu_req", {31'd0, mem_req}, 32'd0);
    drive_e(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    step();
    chk("alu_aluoutw", ALUOutW, 32'h0000_00A5);
    chk("alu_wa3w", {28'd0, WA3W}, 32'd3);
    chk("alu_regww", {31'd0, RegWW}, 32'd1);
    chk("alu_validw", {31'd0, ValidW}, 32'd1);
    chk("alu_req2", {31'd0, mem_req}, 32'd0);
    step();
    chk("bubble_validw", {31'd0, ValidW}, 32'd0);
    chk("bubble_regww", {31'd0, RegWW}, 32'd0);
    chk("bubble_hold", ALUOutW, 32'h0000_00A5);

    // Load acked 3 cycles after request; an ALU op waits behind it in E
    drive_e(1, 1, 0, 1, 32'h0000_0100, 32'h0, 4'd5);
    step();
    stall_cycles = 0;
    if (StallM) stall_cycles++;
    chk("ld_req_detect", {31'd0, mem_req}, 32'd0);
    drive_e(1, 1, 0, 0, 32'h0000_0077, 32'h0, 4'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      if (StallM) stall_cycles++;
      chk("ld_req", {31'd0, mem_req}, 32'd1);
    end
    chk("ld_addr", mem_addr, 32'h0000_0100);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_stall_release", {31'd0, StallM}, 32'd0);
    chk("ld_stall_cycles", stall_cycles, 32'd4);
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    drive_e(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    chk("ld_rdw", ReadDataW, 32'hDEAD_BEEF);
    chk("ld_m2rw", {31'd0, MemtoRegW}, 32'd1);
    chk("ld_regww", {31'd0, RegWW}, 32'd1);
    chk("ld_validw", {31'd0, ValidW}, 32'd1);
    chk("ld_wa3w", {28'd0, WA3W}, 32'd5);
    chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    chk("ld_next_alu", ALUOutW, 32'h0000_0077);
    chk("ld_next_wa3", {28'd0, WA3W}, 32'd6);
    chk("ld_next_rdhold", ReadDataW, 32'hDEAD_BEEF);

    // Store, next instruction enters M on the ack edge
    drive_e(1, 0, 1, 0, 32'h0000_0204, 32'h0000_1234, 4'd0);
    step();
    drive_e(1, 1, 0, 0, 32'h0000_0055, 32'h0, 4'd7);
    step();
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'h0000_1234);
    chk("st_addr", mem_addr, 32'h0000_0204);
    step();
    chk("st_wdata_hold", mem_wdata, 32'h0000_1234);
    chk("st_stall", {31'd0, StallM}, 32'd1);
    mem_ack = 1'b1;
    #1;
    chk("st_stall_release", {31'd0, StallM}, 32'd0);
    step();
    mem_ack = 1'b0;
    drive_e(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    chk("st_validw", {31'd0, ValidW}, 32'd1);
    chk("st_regww", {31'd0, RegWW}, 32'd0);
    chk("st_aluoutw", ALUOutW, 32'h0000_0204);
    step();
    chk("st_next_alu", ALUOutW, 32'h0000_0055);
    chk("st_next_regww", {31'd0, RegWW}, 32'd1);

    // Load never acked: watchdog abort after 16 request cycles
    drive_e(1, 1, 0, 1, 32'h0000_0300, 32'h0, 4'd8);
    step();
    drive_e(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req) req_cycles++;
      else if (req_cycles > 0) break;
      if (req_cycles == 1 && MemErr) chk("to_early_err", {31'd0, MemErr}, 32'd0);
    end
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_memerr", {31'd0, MemErr}, 32'd1);
    chk("to_validw", {31'd0, ValidW}, 32'd1);
    chk("to_regww", {31'd0, RegWW}, 32'd0);
    chk("to_rdw", ReadDataW, 32'd0);
    chk("to_stall", {31'd0, StallM}, 32'd0);
    step();
    chk("to_memerr_sticky", {31'd0, MemErr}, 32'd1);
    chk("to_bubble", {31'd0, ValidW}, 32'd0);

    // Reset during the 2nd access cycle, then a stray ack
    drive_e(1, 1, 0, 1, 32'h0000_0400, 32'h0, 4'd9);
    step();
    drive_e(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    step();
    chk("rs_req_a1", {31'd0, mem_req}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_req", {31'd0, mem_req}, 32'd0);
    chk("rs_addr", mem_addr, 32'd0);
    chk("rs_memerr", {31'd0, MemErr}, 32'd0);
    chk("rs_aluoutw", ALUOutW, 32'd0);
    chk("rs_stall", {31'd0, StallM}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_CAFE;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("rs_late_validw", {31'd0, ValidW}, 32'd0);
    chk("rs_late_rdw", ReadDataW, 32'd0);
    chk("rs_late_req", {31'd0, mem_req}, 32'd0);

    // Two back-to-back loads, each acked in its first access cycle
    drive_e(1, 1, 0, 1, 32'h0000_0500, 32'h0, 4'd1);
    step();
    drive_e(1, 1, 0, 1, 32'h0000_0600, 32'h0, 4'd2);
    step();
    chk("bb_a_req", {31'd0, mem_req}, 32'd1);
    chk("bb_a_addr", mem_addr, 32'h0000_0500);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0111;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    drive_e(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    chk("bb_gap", {31'd0, mem_req}, 32'd0);
    chk("bb_a_rdw", ReadDataW, 32'h0000_0111);
    chk("bb_a_wa3", {28'd0, WA3W}, 32'd1);
    chk("bb_a_validw", {31'd0, ValidW}, 32'd1);
    step();
    chk("bb_b_req", {31'd0, mem_req}, 32'd1);
    chk("bb_b_addr", mem_addr, 32'h0000_0600);
    chk("bb_b_bubble", {31'd0, ValidW}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0222;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("bb_b_rdw", ReadDataW, 32'h0000_0222);
    chk("bb_b_wa3", {28'd0, WA3W}, 32'd2);
    chk("bb_b_validw", {31'd0, ValidW}, 32'd1);
    chk("bb_b_memerr", {31'd0, MemErr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
